// File: rtl/l2_cache_nway_if.sv
// rtl/l2_cache_nway_if.sv - CPU-side and line-memory-side bus bundle for l2_cache_nway
interface l2_cache_nway_if;
   logic [31:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_byte_enable256;
   logic [255:0] mem_wdata256;
   logic [255:0] mem_rdata256;
   logic         mem_resp;
   logic [31:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   // master: the CPU/memory environment; slave: the cache itself
   modport master (
      output mem_address, mem_read, mem_write, mem_byte_enable256, mem_wdata256,
      input  mem_rdata256, mem_resp,
      input  pmem_address, pmem_read, pmem_write, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
   modport slave (
      input  mem_address, mem_read, mem_write, mem_byte_enable256, mem_wdata256,
      output mem_rdata256, mem_resp,
      output pmem_address, pmem_read, pmem_write, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/l2_cache_nway.sv
// rtl/l2_cache_nway.sv - N-way write-back L2 cache with tree-PLRU replacement
// Performance counters exist only when L2_PERF_COUNTERS_EN is defined.
module l2_cache_nway #(
   parameter int s_offset = 5,
   parameter int s_index  = 3,
   parameter int num_ways = 4
) (
   input  logic           clk,
   input  logic           rst,
   l2_cache_nway_if.slave bus,
   output logic [31:0]    hit_count,
   output logic [31:0]    miss_count,
   output logic [31:0]    wb_count
);
   localparam int sets  = 2**s_index;
   localparam int tag_w = 32 - s_offset - s_index;
   localparam int way_w = $clog2(num_ways);

   typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FETCH} state_t;
   state_t state, state_next;

   logic [255:0]        data_arr  [sets][num_ways];
   logic [tag_w-1:0]    tag_arr   [sets][num_ways];
   logic [num_ways-1:0] valid_arr [sets];
   logic [num_ways-1:0] dirty_arr [sets];
   logic [num_ways-2:0] plru_arr  [sets];

   logic [tag_w-1:0]    tag_q;
   logic [s_index-1:0]  idx_q;
   logic [255:0]        wdata_q;
   logic [31:0]         be_q;
   logic                write_q;
   logic [way_w-1:0]    victim_q;

   logic                req;
   logic                hit;
   logic [way_w-1:0]    hit_way;
   logic                has_inv;
   logic [way_w-1:0]    inv_way;
   logic [way_w-1:0]    plru_way;
   logic [way_w-1:0]    victim_c;
   logic                unused_offset;

   assign req           = bus.mem_read | bus.mem_write;
   assign unused_offset = ^bus.mem_address[s_offset-1:0];

   // Every node on the path is pointed at the opposite half from the accessed way.
   function automatic logic [num_ways-2:0] plru_touch(input logic [num_ways-2:0] cur,
                                                       input logic [way_w-1:0]    way);
      logic [num_ways-2:0] r;
      int                  node;
      r    = cur;
      node = 0;
      for (int l = 0; l < way_w; l++) begin
         for (int n = 0; n < num_ways-1; n++)
            if (n == node) r[n] = ~way[way_w-1-l];
         node = 2*node + 1 + int'(way[way_w-1-l]);
      end
      return r;
   endfunction

   function automatic logic [255:0] merge_bytes(input logic [255:0] line,
                                                input logic [255:0] wd,
                                                input logic [31:0]  be);
      logic [255:0] r;
      r = line;
      for (int b = 0; b < 32; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      has_inv = 1'b0;
      inv_way = '0;
      for (int w = num_ways-1; w >= 0; w--) begin
         if (valid_arr[idx_q][w] && tag_arr[idx_q][w] == tag_q) begin
            hit     = 1'b1;
            hit_way = way_w'(w);
         end
         if (!valid_arr[idx_q][w]) begin
            has_inv = 1'b1;
            inv_way = way_w'(w);
         end
      end
   end

   always_comb begin
      int   node;
      int   pw;
      logic b;
      node = 0;
      pw   = 0;
      b    = 1'b0;
      for (int l = 0; l < way_w; l++) begin
         b = 1'b0;
         for (int n = 0; n < num_ways-1; n++)
            if (n == node) b = plru_arr[idx_q][n];
         pw   = pw*2 + int'(b);
         node = 2*node + 1 + int'(b);
      end
      plru_way = way_w'(pw);
      victim_c = has_inv ? inv_way : plru_way;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next       = state;
      bus.mem_resp     = 1'b0;
      bus.mem_rdata256 = '0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      case (state)
         IDLE: if (req) state_next = COMPARE;
         COMPARE: begin
            if (hit) begin
               bus.mem_resp     = 1'b1;
               bus.mem_rdata256 = data_arr[idx_q][hit_way];
               state_next       = IDLE;
            end else if (valid_arr[idx_q][victim_c] && dirty_arr[idx_q][victim_c]) begin
               state_next = WRITEBACK;
            end else begin
               state_next = FETCH;
            end
         end
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_arr[idx_q][victim_q], idx_q, {s_offset{1'b0}}};
            bus.pmem_wdata   = data_arr[idx_q][victim_q];
            if (bus.pmem_resp) state_next = FETCH;
         end
         FETCH: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {tag_q, idx_q, {s_offset{1'b0}}};
            if (bus.pmem_resp) state_next = COMPARE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < sets; s++) begin
            valid_arr[s] <= '0;
            dirty_arr[s] <= '0;
            plru_arr[s]  <= '0;
         end
         tag_q    <= '0;
         idx_q    <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         write_q  <= 1'b0;
         victim_q <= '0;
      end else begin
         case (state)
            IDLE: if (req) begin
               tag_q   <= bus.mem_address[31 -: tag_w];
               idx_q   <= bus.mem_address[s_offset +: s_index];
               wdata_q <= bus.mem_wdata256;
               be_q    <= bus.mem_byte_enable256;
               write_q <= bus.mem_write;
            end
            COMPARE: begin
               if (hit) begin
                  plru_arr[idx_q] <= plru_touch(plru_arr[idx_q], hit_way);
                  if (write_q && |be_q) dirty_arr[idx_q][hit_way] <= 1'b1;
               end else begin
                  victim_q <= victim_c;
               end
            end
            WRITEBACK: if (bus.pmem_resp) dirty_arr[idx_q][victim_q] <= 1'b0;
            FETCH: if (bus.pmem_resp) begin
               valid_arr[idx_q][victim_q] <= 1'b1;
               dirty_arr[idx_q][victim_q] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Line storage carries no reset; valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (state == COMPARE && hit && write_q)
         data_arr[idx_q][hit_way] <= merge_bytes(data_arr[idx_q][hit_way], wdata_q, be_q);
      if (state == FETCH && bus.pmem_resp) begin
         data_arr[idx_q][victim_q] <= bus.pmem_rdata;
         tag_arr[idx_q][victim_q]  <= tag_q;
      end
   end

`ifdef L2_PERF_COUNTERS_EN
   logic first_q;

   // The hit that follows a fill is not a first-pass hit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         first_q    <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (state == IDLE && req)                     first_q    <= 1'b1;
         if (state == COMPARE && !hit)                 first_q    <= 1'b0;
         if (state == COMPARE && hit && first_q)       hit_count  <= hit_count + 32'd1;
         if (state == COMPARE && !hit)                 miss_count <= miss_count + 32'd1;
         if (state == WRITEBACK && bus.pmem_resp)      wb_count   <= wb_count + 32'd1;
      end
   end
`else
   assign hit_count  = '0;
   assign miss_count = '0;
   assign wb_count   = '0;
`endif
endmodule

// File: tb/tb_l2_cache_nway.sv
// tb/tb_l2_cache_nway.sv - randomized bench for l2_cache_nway against a cache/memory reference model
module tb_l2_cache_nway;
   localparam int SETS = 8;
   localparam int WAYS = 4;

   logic        clk;
   logic        rst;
   logic [31:0] hit_count, miss_count, wb_count;
   l2_cache_nway_if bus();

   l2_cache_nway #(.s_offset(5), .s_index(3), .num_ways(4)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Backing memory (pmem) and the CPU-visible memory (arch), both lazily initialised.
   logic [255:0] pmem [logic [26:0]];
   logic [255:0] arch [logic [26:0]];

   function automatic logic [255:0] init_line(input logic [26:0] la);
      logic [255:0] r;
      for (int k = 0; k < 8; k++)
         r[32*k +: 32] = {5'b0, la} * 32'h9E3779B1 + 32'(k) * 32'h01000193;
      return r;
   endfunction

   function automatic logic [255:0] pm_get(input logic [26:0] la);
      return pmem.exists(la) ? pmem[la] : init_line(la);
   endfunction

   function automatic logic [255:0] arch_get(input logic [26:0] la);
      return arch.exists(la) ? arch[la] : init_line(la);
   endfunction

   // Memory-side responder with random latency.
   int           fetch_cnt = 0;
   int           wb_cnt_tb = 0;
   logic [31:0]  last_fetch_addr = '0;
   logic [31:0]  last_wb_addr = '0;
   logic [255:0] last_wb_data = '0;

   initial begin
      int lat_cnt;
      lat_cnt = -1;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.pmem_resp) begin
            bus.pmem_resp = 1'b0;
            lat_cnt = -1;
         end else if (rst && (bus.pmem_read || bus.pmem_write)) begin
            if (lat_cnt < 0) lat_cnt = $urandom_range(0, 3);
            if (lat_cnt == 0) begin
               if (bus.pmem_write) begin
                  pmem[bus.pmem_address[31:5]] = bus.pmem_wdata;
                  last_wb_addr = bus.pmem_address;
                  last_wb_data = bus.pmem_wdata;
                  wb_cnt_tb++;
               end else begin
                  bus.pmem_rdata = pm_get(bus.pmem_address[31:5]);
                  last_fetch_addr = bus.pmem_address;
                  fetch_cnt++;
               end
               bus.pmem_resp = 1'b1;
               lat_cnt = -1;
            end else begin
               lat_cnt--;
            end
         end else begin
            lat_cnt = -1;
         end
      end
   end

   initial begin
      @(posedge rst);
      forever begin
         @(negedge clk);
         check("pmem_excl", 256'(bus.pmem_read & bus.pmem_write), 256'(0));
         check("resp_during_pmem", 256'(bus.mem_resp & (bus.pmem_read | bus.pmem_write)), 256'(0));
      end
   end

   // Reference cache state: which lines are resident where, dirty flags, tree-PLRU bits.
   bit          m_valid [SETS][WAYS];
   bit          m_dirty [SETS][WAYS];
   logic [23:0] m_tag   [SETS][WAYS];
   bit          m_plru  [SETS][WAYS-1];
   int          n_hit_exp, n_miss_exp, n_wb_exp;

   function automatic int plru_pick(input int s);
      int lo, hi, n, mid;
      lo = 0; hi = WAYS; n = 0;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (!m_plru[s][n]) begin hi = mid; n = 2*n + 1; end
         else               begin lo = mid; n = 2*n + 2; end
      end
      return lo;
   endfunction

   task automatic plru_use(input int s, input int w);
      int lo, hi, n, mid;
      lo = 0; hi = WAYS; n = 0;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (w < mid) begin m_plru[s][n] = 1'b1; hi = mid; n = 2*n + 1; end
         else         begin m_plru[s][n] = 1'b0; lo = mid; n = 2*n + 2; end
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_tag[s][w]   = '0;
         end
         for (int n = 0; n < WAYS-1; n++) m_plru[s][n] = 1'b0;
      end
      n_hit_exp = 0; n_miss_exp = 0; n_wb_exp = 0;
      arch = pmem;
   endtask

   task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] be,
                               input logic [255:0] wd, output bit hit, output bit wb,
                               output logic [31:0] wb_a, output logic [255:0] wb_d);
      int s, w;
      logic [23:0]  t;
      logic [255:0] line;
      s = int'(a[7:5]); t = a[31:8]; w = -1;
      wb = 1'b0; wb_a = '0; wb_d = '0;
      for (int i = 0; i < WAYS; i++)
         if (m_valid[s][i] && m_tag[s][i] == t) w = i;
      hit = (w >= 0);
      if (hit) n_hit_exp++;
      else begin
         n_miss_exp++;
         for (int i = WAYS-1; i >= 0; i--)
            if (!m_valid[s][i]) w = i;
         if (w < 0) w = plru_pick(s);
         if (m_valid[s][w] && m_dirty[s][w]) begin
            wb   = 1'b1;
            wb_a = {m_tag[s][w], 3'(s), 5'b0};
            wb_d = arch_get(wb_a[31:5]);
            n_wb_exp++;
         end
         m_valid[s][w] = 1'b1; m_dirty[s][w] = 1'b0; m_tag[s][w] = t;
      end
      plru_use(s, w);
      if (wr && be != 0) begin
         m_dirty[s][w] = 1'b1;
         line = arch_get(a[31:5]);
         for (int b = 0; b < 32; b++)
            if (be[b]) line[8*b +: 8] = wd[8*b +: 8];
         arch[a[31:5]] = line;
      end
   endtask

   task automatic check_counters();
`ifdef L2_PERF_COUNTERS_EN
      check("hit_count", 256'(hit_count), 256'(n_hit_exp));
      check("miss_count", 256'(miss_count), 256'(n_miss_exp));
      check("wb_count", 256'(wb_count), 256'(n_wb_exp));
`else
      check("hit_count", 256'(hit_count), 256'(0));
      check("miss_count", 256'(miss_count), 256'(0));
      check("wb_count", 256'(wb_count), 256'(0));
`endif
   endtask

   task automatic do_req(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] be,
                         input logic [255:0] wd, output logic [255:0] rdata);
      bit eh, ewb, got;
      logic [31:0]  ewa;
      logic [255:0] ewd, erd;
      int f0, w0, lat;
      model_access(a, wr, be, wd, eh, ewb, ewa, ewd);
      erd = arch_get(a[31:5]);
      f0 = fetch_cnt; w0 = wb_cnt_tb;
      @(negedge clk);
      bus.mem_address = a; bus.mem_read = rd; bus.mem_write = wr;
      bus.mem_byte_enable256 = be; bus.mem_wdata256 = wd;
      lat = 0; got = 1'b0; rdata = '0;
      while (!got && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.mem_resp) begin got = 1'b1; rdata = bus.mem_rdata256; end
      end
      bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      check("resp_seen", 256'(got), 256'(1));
      if (!wr) check("rdata", rdata, erd);
      if (eh) check("hit_latency", 256'(lat + 1), 256'(2));
      check("fetches", 256'(fetch_cnt - f0), 256'(eh ? 0 : 1));
      if (!eh) check("fetch_addr", 256'(last_fetch_addr), 256'({a[31:5], 5'b0}));
      check("writebacks", 256'(wb_cnt_tb - w0), 256'(ewb));
      if (ewb) begin
         check("wb_addr", 256'(last_wb_addr), 256'(ewa));
         check("wb_data", last_wb_data, ewd);
      end
      check_counters();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [255:0] rdo, wd;
      int w0, tries;
      rst = 1'b0;
      bus.mem_address = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      bus.mem_byte_enable256 = '0; bus.mem_wdata256 = '0;

      // Outputs must already be zero before any clock edge.
      #3;
      check("rst_mem_resp", 256'(bus.mem_resp), 256'(0));
      check("rst_mem_rdata", bus.mem_rdata256, 256'(0));
      check("rst_pmem_read", 256'(bus.pmem_read), 256'(0));
      check("rst_pmem_write", 256'(bus.pmem_write), 256'(0));
      check("rst_pmem_addr", 256'(bus.pmem_address), 256'(0));
      check("rst_pmem_wdata", bus.pmem_wdata, 256'(0));
      model_reset();
      check_counters();
      @(negedge clk);
      rst = 1'b1;

      // Fill then hit on 0x100; dirty write and eviction by same-index lines.
      do_req(32'h0000_0100, 1'b1, 1'b0, '0, '0, rdo);
      do_req(32'h0000_0100, 1'b1, 1'b0, '0, '0, rdo);
      check("repeat_read_data", rdo, init_line(27'h8));
      wd = '0; wd[31:0] = 32'hDEADBEEF;
      do_req(32'h0000_0100, 1'b0, 1'b1, 32'h0000_000F, wd, rdo);
      w0 = wb_cnt_tb;
      for (int t = 2; t <= 6; t++)
         do_req(32'(t) << 8, 1'b1, 1'b0, '0, '0, rdo);
      check("evict_wb_num", 256'(wb_cnt_tb - w0), 256'(1));
      check("evict_wb_addr", 256'(last_wb_addr), 256'(32'h0000_0100));
      check("evict_wb_word", 256'(last_wb_data[31:0]), 256'(32'hDEADBEEF));

      // PLRU order: dirty ways 0..3, touch 0 and 2, miss must evict way 1 (tag 1).
      do_reset();
      for (int t = 0; t < 4; t++)
         do_req(32'(t) << 8, 1'b0, 1'b1, 32'hFFFF_FFFF, {8{32'(t) + 32'h5A00}}, rdo);
      do_req(32'h0000_0000, 1'b1, 1'b0, '0, '0, rdo);
      do_req(32'h0000_0200, 1'b1, 1'b0, '0, '0, rdo);
      do_req(32'h0000_0400, 1'b1, 1'b0, '0, '0, rdo);
      check("plru_victim_addr", 256'(last_wb_addr), 256'(32'h0000_0100));

      // Both strobes on a hit act as a full-line write.
      for (int j = 0; j < 8; j++) wd[32*j +: 32] = $urandom;
      do_req(32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, wd, rdo);
      do_req(32'h0000_0000, 1'b1, 1'b0, '0, '0, rdo);
      check("rw_both_data", rdo, wd);

      // Reset in the middle of a fetch drops pmem_read without a clock edge.
      @(negedge clk);
      bus.mem_address = 32'h0000_1F20; bus.mem_read = 1'b1;
      tries = 0;
      while (!bus.pmem_read && tries < 50) begin @(negedge clk); tries++; end
      check("fetch_started", 256'(bus.pmem_read), 256'(1));
      #2;
      rst = 1'b0;
      #1;
      check("rst_drop_pmem_read", 256'(bus.pmem_read), 256'(0));
      check("rst_drop_addr", 256'(bus.pmem_address), 256'(0));
      check("rst_drop_resp", 256'(bus.mem_resp), 256'(0));
      bus.mem_read = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
      check_counters();
      do_req(32'h0000_1F20, 1'b1, 1'b0, '0, '0, rdo);

      // Random traffic over a small tag pool to force conflicts and evictions.
      for (int i = 0; i < 300; i++) begin
         logic [31:0]  a, be;
         logic [255:0] d;
         bit rd, wr;
         int k;
         a = {24'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
         k = $urandom_range(0, 9);
         rd = (k < 5) || (k == 9);
         wr = (k >= 5);
         case ($urandom_range(0, 3))
            0:       be = '0;
            1:       be = '1;
            default: be = $urandom;
         endcase
         for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
         do_req(a, rd, wr, be, d, rdo);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/l2_cache_nway.md
L2_CACHE_NWAY -- requirements
Module: l2_cache_nway

Interface
REQ-001 SHALL have parameter s_offset, default 5, meaning byte-offset bits; line is 2**s_offset bytes, and 5 is the only supported value (256-bit line).
REQ-002 SHALL have parameter s_index, default 3, meaning set-index bits; sets = 2**s_index; supported range 1..8.
REQ-003 SHALL have parameter num_ways, default 4, meaning associativity; supported values are 2, 4 or 8.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port mem_address, input, 32 bits, CPU line address; bits [s_offset-1:0] are ignored.
REQ-007 SHALL have ports mem_read and mem_write, input, 1 bit each, CPU request strobes, held until mem_resp.
REQ-008 SHALL have ports mem_byte_enable256 (input, 32 bits) and mem_wdata256 (input, 256 bits), CPU write mask and data.
REQ-009 SHALL have ports mem_rdata256 (output, 256 bits) and mem_resp (output, 1 bit), read data and one-cycle completion pulse.
REQ-010 SHALL have ports pmem_address (output, 32), pmem_read (output, 1), pmem_write (output, 1), pmem_wdata (output, 256), pmem_rdata (input, 256) and pmem_resp (input, 1), forming the line-granular memory side.
REQ-011 SHALL have ports hit_count, miss_count and wb_count, output, 32 bits each, performance counters (see Configuration).

Function
REQ-012 SHALL implement states IDLE, COMPARE, WRITEBACK and FETCH.
REQ-013 In IDLE with mem_read or mem_write high, SHALL latch address, wdata, byte enables and operation, then go to COMPARE next cycle; both strobes high SHALL be treated as a write.
REQ-014 In COMPARE, a hit (valid and tag equal in any way) SHALL assert mem_resp for exactly that cycle, update PLRU and return to IDLE; hit latency is 2 cycles from request.
REQ-015 On a read hit, mem_rdata256 SHALL equal the hit way's line during the mem_resp cycle.
REQ-016 On a write hit, SHALL merge only enabled bytes into the hit way and set its dirty bit if any enable bit is 1; all-zero enables leave data and dirty unchanged but still respond.
REQ-017 On a miss, the victim SHALL be the lowest-index invalid way, else the tree-PLRU way; a dirty victim SHALL go to WRITEBACK, a clean victim to FETCH.
REQ-018 In WRITEBACK, SHALL hold pmem_write=1, pmem_address={victim tag, index, zeros} and pmem_wdata=victim line until pmem_resp, then go to FETCH and clear the victim's dirty bit.
REQ-019 In FETCH, SHALL hold pmem_read=1 and pmem_address={latched tag, index, zeros} until pmem_resp.
REQ-020 On pmem_resp in FETCH, SHALL write pmem_rdata into the victim with valid=1, dirty=0 and the new tag, then return to COMPARE, where it hits.
REQ-021 The PLRU SHALL use num_ways-1 bits per set; bit 0 at a node selects the lower half; an access SHALL set every node on the accessed way's path to point away from it.
REQ-022 pmem_resp outside WRITEBACK/FETCH and strobe changes outside IDLE SHALL be ignored.
REQ-023 pmem_read and pmem_write SHALL never be high together; mem_resp SHALL never be high outside COMPARE.

Reset
REQ-024 While rst=0, all outputs SHALL be 0 and the FSM in IDLE; all valid, dirty and PLRU bits and all counters SHALL clear asynchronously, without waiting for a clk edge.
REQ-025 Reset mid-miss SHALL drop the request and deassert pmem strobes immediately; data-array contents are don't-care after reset.

Configuration
REQ-026 With macro L2_PERF_COUNTERS_EN defined, hit_count SHALL increment on each first-pass COMPARE hit.
REQ-027 With L2_PERF_COUNTERS_EN defined, miss_count SHALL increment on each COMPARE miss and wb_count on each WRITEBACK completion; all three counters wrap at 2**32.
REQ-028 Without L2_PERF_COUNTERS_EN, the three counter ports SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-029 Reset, then read 0x0000_0100: FETCH with pmem_address=0x0000_0100, response after fill; a repeat read hits 2 cycles after request with mem_resp=1 and the same data.
REQ-030 Write 0x0000_0100 with enables 0x0000_000F and wdata low word 0xDEADBEEF, then fill 5 lines with the same index (num_ways=4): the evicted line is written back with low word 0xDEADBEEF, and wb_count=1 when the macro is on.
REQ-031 PLRU order: fill ways 0..3 in set 0, access ways 0 and 2, then miss: victim is way 1.
REQ-032 Assert rst low while pmem_read is high in FETCH: pmem_read=0 in the same cycle; after release, a read of the same address misses.
REQ-033 Assert mem_read and mem_write together on a hit with enables 0xFFFF_FFFF: treated as a write, and a subsequent read returns mem_wdata256.
